udma_jtag_fifo_ctrl: RTL and testbench

Transfer sequencer for the JTAG FIFO word streams, in the uDMA peripheral clock domain downstream of the JTAG-side CDC. Programmed with per-direction word counts. Moves RX words (JTAG→L2) into the uDMA RX channel and fetches TX words (L2→JTAG) through the uDMA TX req/gnt protocol. Produces end-of-transfer events and busy/remaining status for the register file.

---
 rtl/udma_jtag_fifo_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_udma_jtag_fifo_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_jtag_fifo_ctrl.sv
// JTAG FIFO transfer sequencer: streams RX words into the uDMA RX channel and
// fetches TX words from L2 via req/gnt, with per-direction counts and EOT events.
module udma_jtag_fifo_ctrl #(
  parameter int unsigned LEN_W     = 16,
  parameter bit          DROP_IDLE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_rx_start_i,
  input  logic [LEN_W-1:0] cfg_rx_len_i,
  input  logic             cfg_rx_clr_i,
  input  logic             cfg_tx_start_i,
  input  logic [LEN_W-1:0] cfg_tx_len_i,
  input  logic             cfg_tx_clr_i,
  output logic             cfg_rx_busy_o,
  output logic [LEN_W-1:0] cfg_rx_remain_o,
  output logic             cfg_tx_busy_o,
  output logic [LEN_W-1:0] cfg_tx_remain_o,
  input  logic [31:0]      jtag_rx_data_i,
  input  logic             jtag_rx_valid_i,
  output logic             jtag_rx_ready_o,
  output logic [31:0]      udma_rx_data_o,
  output logic             udma_rx_valid_o,
  input  logic             udma_rx_ready_i,
  output logic             udma_tx_req_o,
  input  logic             udma_tx_gnt_i,
  input  logic [31:0]      udma_tx_data_i,
  input  logic             udma_tx_valid_i,
  output logic             udma_tx_ready_o,
  output logic [31:0]      jtag_tx_data_o,
  output logic             jtag_tx_valid_o,
  input  logic             jtag_tx_ready_i,
  output logic             evt_rx_eot_o,
  output logic             evt_tx_eot_o,
  output logic             rx_drop_o
);

  typedef enum logic [1:0] {RX_IDLE, RX_RUN, RX_DRAIN} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_DATA} tx_state_e;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  rx_state_e        rx_state_q, rx_state_d;
  logic [LEN_W-1:0] rx_remain_q, rx_remain_d;
  logic [31:0]      rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_eot_q, rx_eot_d;
  logic             rx_drop_q, rx_drop_d;

  tx_state_e        tx_state_q, tx_state_d;
  logic [LEN_W-1:0] tx_remain_q, tx_remain_d;
  logic [31:0]      tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             tx_eot0_q, tx_eot0_d;
  logic             tx_discard_q, tx_discard_d;

  logic rx_ready, rx_acc, rx_out_acc;
  logic tx_req, tx_ready, tx_load, tx_out_acc, tx_last_acc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_state_q   <= RX_IDLE;
      rx_remain_q  <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_eot_q     <= 1'b0;
      rx_drop_q    <= 1'b0;
      tx_state_q   <= TX_IDLE;
      tx_remain_q  <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      tx_eot0_q    <= 1'b0;
      tx_discard_q <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_remain_q  <= rx_remain_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_eot_q     <= rx_eot_d;
      rx_drop_q    <= rx_drop_d;
      tx_state_q   <= tx_state_d;
      tx_remain_q  <= tx_remain_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      tx_eot0_q    <= tx_eot0_d;
      tx_discard_q <= tx_discard_d;
    end
  end

  // RX: one-entry output register, refilled in the same cycle it drains
  always_comb begin
    rx_ready = 1'b0;
    case (rx_state_q)
      RX_IDLE: rx_ready = DROP_IDLE;
      RX_RUN:  rx_ready = !rx_valid_q || udma_rx_ready_i;
      default: rx_ready = 1'b0;
    endcase
    if (cfg_rx_clr_i) rx_ready = 1'b0;
  end

  assign rx_acc     = jtag_rx_valid_i && rx_ready;
  assign rx_out_acc = rx_valid_q && udma_rx_ready_i;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_remain_d = rx_remain_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q && !rx_out_acc;
    rx_eot_d    = 1'b0;
    rx_drop_d   = 1'b0;
    if (cfg_rx_clr_i) begin
      rx_state_d  = RX_IDLE;
      rx_remain_d = '0;
      rx_data_d   = '0;
      rx_valid_d  = 1'b0;
      rx_drop_d   = rx_valid_q && !rx_out_acc;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          rx_drop_d = rx_acc;
          if (cfg_rx_start_i) begin
            if (cfg_rx_len_i == '0) begin
              rx_eot_d = 1'b1;
            end else begin
              rx_state_d  = RX_RUN;
              rx_remain_d = cfg_rx_len_i;
            end
          end
        end
        RX_RUN: begin
          if (rx_acc && rx_remain_q != '0) begin
            rx_data_d   = jtag_rx_data_i;
            rx_valid_d  = 1'b1;
            rx_remain_d = rx_remain_q - ONE;
            if (rx_remain_q == ONE) rx_state_d = RX_DRAIN;
          end
        end
        RX_DRAIN: begin
          if (!rx_valid_d) begin
            rx_state_d = RX_IDLE;
            rx_eot_d   = 1'b1;
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  // TX: a request is raised only once the JTAG-side register has drained, and
  // a word granted before a clear is still swallowed via tx_discard_q
  assign tx_req      = (tx_state_q == TX_REQ) && !tx_valid_q && !tx_discard_q && !cfg_tx_clr_i;
  assign tx_ready    = tx_discard_q || ((tx_state_q == TX_DATA) && !tx_valid_q);
  assign tx_load     = udma_tx_valid_i && (tx_state_q == TX_DATA) && !tx_valid_q && !tx_discard_q;
  assign tx_out_acc  = tx_valid_q && jtag_tx_ready_i;
  assign tx_last_acc = (tx_state_q == TX_DATA) && (tx_remain_q == '0) && tx_out_acc && !cfg_tx_clr_i;

  always_comb begin
    tx_state_d   = tx_state_q;
    tx_remain_d  = tx_remain_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q && !tx_out_acc;
    tx_eot0_d    = 1'b0;
    tx_discard_d = tx_discard_q && !udma_tx_valid_i;
    if (cfg_tx_clr_i) begin
      tx_state_d   = TX_IDLE;
      tx_remain_d  = '0;
      tx_data_d    = '0;
      tx_valid_d   = 1'b0;
      tx_discard_d = tx_discard_d ||
                     ((tx_state_q == TX_DATA) && !tx_valid_q && !udma_tx_valid_i);
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (cfg_tx_start_i) begin
            if (cfg_tx_len_i == '0) begin
              tx_eot0_d = 1'b1;
            end else begin
              tx_state_d  = TX_REQ;
              tx_remain_d = cfg_tx_len_i;
            end
          end
        end
        TX_REQ: begin
          if (tx_req && udma_tx_gnt_i && tx_remain_q != '0) begin
            tx_remain_d = tx_remain_q - ONE;
            tx_state_d  = TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_load) begin
            tx_data_d  = udma_tx_data_i;
            tx_valid_d = 1'b1;
            if (tx_remain_q != '0) tx_state_d = TX_REQ;
          end else if (tx_last_acc) begin
            tx_state_d = TX_IDLE;
          end
        end
        default: tx_state_d = TX_IDLE;
      endcase
    end
  end

  assign cfg_rx_busy_o   = (rx_state_q != RX_IDLE);
  assign cfg_rx_remain_o = rx_remain_q;
  assign cfg_tx_busy_o   = (tx_state_q != TX_IDLE);
  assign cfg_tx_remain_o = tx_remain_q;
  assign jtag_rx_ready_o = rx_ready;
  assign udma_rx_data_o  = rx_data_q;
  assign udma_rx_valid_o = rx_valid_q;
  assign udma_tx_req_o   = tx_req;
  assign udma_tx_ready_o = tx_ready;
  assign jtag_tx_data_o  = tx_data_q;
  assign jtag_tx_valid_o = tx_valid_q;
  assign evt_rx_eot_o    = rx_eot_q;
  assign evt_tx_eot_o    = tx_eot0_q || tx_last_acc;
  assign rx_drop_o       = rx_drop_q;

endmodule

// File: tb/tb_udma_jtag_fifo_ctrl.sv
// Directed bench for udma_jtag_fifo_ctrl; a second instance covers DROP_IDLE=1.
module tb_udma_jtag_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_start, rx_clr, tx_start, tx_clr;
  logic [15:0] rx_len, tx_len;
  logic [31:0] jrx_data, utx_data;
  logic        jrx_valid, urx_ready, utx_gnt, utx_valid, jtx_ready;

  logic        rx_busy, tx_busy, jrx_ready, urx_valid, utx_req, utx_ready;
  logic        jtx_valid, rx_eot, tx_eot, rx_drop;
  logic [15:0] rx_remain, tx_remain;
  logic [31:0] urx_data, jtx_data;

  logic        d1_rx_busy, d1_tx_busy, d1_jrx_ready, d1_urx_valid, d1_utx_req, d1_utx_ready;
  logic        d1_jtx_valid, d1_rx_eot, d1_tx_eot, d1_rx_drop;
  logic [15:0] d1_rx_remain, d1_tx_remain;
  logic [31:0] d1_urx_data, d1_jtx_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  udma_jtag_fifo_ctrl #(.LEN_W(16), .DROP_IDLE(1'b0)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_rx_start_i(rx_start), .cfg_rx_len_i(rx_len), .cfg_rx_clr_i(rx_clr),
    .cfg_tx_start_i(tx_start), .cfg_tx_len_i(tx_len), .cfg_tx_clr_i(tx_clr),
    .cfg_rx_busy_o(rx_busy), .cfg_rx_remain_o(rx_remain),
    .cfg_tx_busy_o(tx_busy), .cfg_tx_remain_o(tx_remain),
    .jtag_rx_data_i(jrx_data), .jtag_rx_valid_i(jrx_valid), .jtag_rx_ready_o(jrx_ready),
    .udma_rx_data_o(urx_data), .udma_rx_valid_o(urx_valid), .udma_rx_ready_i(urx_ready),
    .udma_tx_req_o(utx_req), .udma_tx_gnt_i(utx_gnt),
    .udma_tx_data_i(utx_data), .udma_tx_valid_i(utx_valid), .udma_tx_ready_o(utx_ready),
    .jtag_tx_data_o(jtx_data), .jtag_tx_valid_o(jtx_valid), .jtag_tx_ready_i(jtx_ready),
    .evt_rx_eot_o(rx_eot), .evt_tx_eot_o(tx_eot), .rx_drop_o(rx_drop)
  );

  udma_jtag_fifo_ctrl #(.LEN_W(16), .DROP_IDLE(1'b1)) dut_drop (
    .clk_i(clk), .rst_i(rst),
    .cfg_rx_start_i(rx_start), .cfg_rx_len_i(rx_len), .cfg_rx_clr_i(rx_clr),
    .cfg_tx_start_i(tx_start), .cfg_tx_len_i(tx_len), .cfg_tx_clr_i(tx_clr),
    .cfg_rx_busy_o(d1_rx_busy), .cfg_rx_remain_o(d1_rx_remain),
    .cfg_tx_busy_o(d1_tx_busy), .cfg_tx_remain_o(d1_tx_remain),
    .jtag_rx_data_i(jrx_data), .jtag_rx_valid_i(jrx_valid), .jtag_rx_ready_o(d1_jrx_ready),
    .udma_rx_data_o(d1_urx_data), .udma_rx_valid_o(d1_urx_valid), .udma_rx_ready_i(urx_ready),
    .udma_tx_req_o(d1_utx_req), .udma_tx_gnt_i(utx_gnt),
    .udma_tx_data_i(utx_data), .udma_tx_valid_i(utx_valid), .udma_tx_ready_o(d1_utx_ready),
    .jtag_tx_data_o(d1_jtx_data), .jtag_tx_valid_o(d1_jtx_valid), .jtag_tx_ready_i(jtx_ready),
    .evt_rx_eot_o(d1_rx_eot), .evt_tx_eot_o(d1_tx_eot), .rx_drop_o(d1_rx_drop)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  sent, got;
    bit  eot_exp, done, jacc;

    rst = 1'b1;
    rx_start = 0; rx_clr = 0; tx_start = 0; tx_clr = 0;
    rx_len = '0; tx_len = '0;
    jrx_data = '0; jrx_valid = 0; urx_ready = 0;
    utx_gnt = 0; utx_data = '0; utx_valid = 0; jtx_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_busy", rx_busy, 0);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_jrx_ready", jrx_ready, 0);
    chk("rst_urx_valid", urx_valid, 0);
    chk("rst_utx_req", utx_req, 0);
    chk("rst_utx_ready", utx_ready, 0);
    chk("rst_jtx_valid", jtx_valid, 0);
    chk("rst_evts", {rx_eot, tx_eot, rx_drop}, 0);
    chk("rst_data", urx_data | jtx_data, 0);
    chk("rst_remain", {rx_remain, tx_remain}, 0);
    rst = 1'b0;
    tick();

    // RX len=4, back-to-back, udma always ready
    rx_start = 1; rx_len = 16'd4;
    #1 chk("t1_busy_pre", rx_busy, 0);
    tick();
    rx_start = 0; jrx_valid = 1; jrx_data = 32'hA0; urx_ready = 1;
    #1;
    chk("t1_busy", rx_busy, 1);
    chk("t1_remain4", rx_remain, 4);
    chk("t1_jready", jrx_ready, 1);
    chk("t1_nvalid", urx_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_valid", urx_valid, 1);
      chk("t1_data", urx_data, 32'hA0 + i);
      chk("t1_remain", rx_remain, 3 - i);
      if (i < 3) jrx_data = 32'hA1 + i;
      else       jrx_valid = 0;
    end
    #1;
    chk("t1_drain_ready", jrx_ready, 0);
    chk("t1_drain_eot", rx_eot, 0);
    chk("t1_drain_busy", rx_busy, 1);
    tick();
    chk("t1_eot", rx_eot, 1);
    chk("t1_busy_end", rx_busy, 0);
    chk("t1_valid_end", urx_valid, 0);
    tick();
    chk("t1_eot_once", rx_eot, 0);

    // RX len=3, udma ready toggling
    rx_start = 1; rx_len = 16'd3;
    tick();
    rx_start = 0; jrx_valid = 1; jrx_data = 32'hC0;
    sent = 0; got = 0; eot_exp = 0; done = 0;
    for (int cyc = 0; cyc < 24 && !done; cyc++) begin
      urx_ready = (cyc % 2 == 0);
      #1;
      chk("t2_eot", rx_eot, eot_exp);
      if (eot_exp) begin
        chk("t2_busy_end", rx_busy, 0);
        done = 1;
      end
      eot_exp = 0;
      if (sent < 3) chk("t2_jready", jrx_ready, !(urx_valid && !urx_ready));
      if (urx_valid && urx_ready) begin
        chk("t2_data", urx_data, 32'hC0 + got);
        got++;
        if (got == 3) eot_exp = 1;
      end
      jacc = jrx_valid && jrx_ready;
      tick();
      if (jacc) begin
        sent++;
        jrx_data = 32'hC0 + sent;
        if (sent == 3) jrx_valid = 0;
      end
    end
    chk("t2_done", done, 1);
    chk("t2_count", got, 3);
    urx_ready = 0;

    // TX len=2
    tx_start = 1; tx_len = 16'd2;
    tick();
    tx_start = 0;
    chk("t3_req1", utx_req, 1);
    chk("t3_busy", tx_busy, 1);
    chk("t3_remain2", tx_remain, 2);
    tick();
    utx_gnt = 1;
    #1 chk("t3_req1b", utx_req, 1);
    tick();
    utx_gnt = 0;
    chk("t3_req_off", utx_req, 0);
    chk("t3_ready", utx_ready, 1);
    chk("t3_remain1", tx_remain, 1);
    tick();
    utx_valid = 1; utx_data = 32'hB0;
    tick();
    utx_valid = 0;
    chk("t3_jv0", jtx_valid, 1);
    chk("t3_jd0", jtx_data, 32'hB0);
    chk("t3_req_full", utx_req, 0);
    chk("t3_eot_early", tx_eot, 0);
    tick();
    chk("t3_jv_empty", jtx_valid, 0);
    chk("t3_req2", utx_req, 1);
    utx_gnt = 1;
    tick();
    utx_gnt = 0;
    chk("t3_remain0", tx_remain, 0);
    chk("t3_req_off2", utx_req, 0);
    tick();
    utx_valid = 1; utx_data = 32'hB1;
    tick();
    utx_valid = 0;
    #1;
    chk("t3_jv1", jtx_valid, 1);
    chk("t3_jd1", jtx_data, 32'hB1);
    chk("t3_eot", tx_eot, 1);
    chk("t3_last_ready", utx_ready, 0);
    tick();
    chk("t3_busy_end", tx_busy, 0);
    chk("t3_eot_once", tx_eot, 0);
    chk("t3_jv_end", jtx_valid, 0);

    // Zero-length starts on both directions
    rx_start = 1; rx_len = '0; tx_start = 1; tx_len = '0;
    tick();
    rx_start = 0; tx_start = 0;
    chk("t4_rx_eot", rx_eot, 1);
    chk("t4_tx_eot", tx_eot, 1);
    chk("t4_busy", {rx_busy, tx_busy}, 0);
    tick();
    chk("t4_eots_off", {rx_eot, tx_eot}, 0);
    chk("t4_busy2", {rx_busy, tx_busy}, 0);

    // RX len=5 cleared with a word held, then idle-word policy
    rx_start = 1; rx_len = 16'd5;
    tick();
    rx_start = 0; jrx_valid = 1; jrx_data = 32'hD0; urx_ready = 0;
    tick();
    jrx_data = 32'hD1; urx_ready = 1;
    #1 chk("t5_jready", jrx_ready, 1);
    tick();
    urx_ready = 0; jrx_valid = 0; rx_clr = 1;
    #1;
    chk("t5_held", urx_data, 32'hD1);
    chk("t5_remain3", rx_remain, 3);
    tick();
    rx_clr = 0;
    chk("t5_busy", rx_busy, 0);
    chk("t5_valid", urx_valid, 0);
    chk("t5_remain0", rx_remain, 0);
    chk("t5_clr_drop", rx_drop, 1);
    chk("t5_no_eot", rx_eot, 0);
    jrx_valid = 1; jrx_data = 32'hEE;
    #1;
    chk("t5_idle_ready0", jrx_ready, 0);
    chk("t5_idle_ready1", d1_jrx_ready, 1);
    tick();
    jrx_valid = 0;
    chk("t5_drop0", rx_drop, 0);
    chk("t5_drop1", d1_rx_drop, 1);
    chk("t5_d1_valid", d1_urx_valid, 0);
    chk("t5_d1_busy", d1_rx_busy, 0);
    chk("t5_no_eot2", {rx_eot, d1_rx_eot}, 0);
    tick();
    chk("t5_drop1_once", d1_rx_drop, 0);

    // TX len=3 cleared after gnt, late word discarded, then len=1
    tx_start = 1; tx_len = 16'd3;
    tick();
    tx_start = 0;
    chk("t6_req", utx_req, 1);
    utx_gnt = 1;
    tick();
    utx_gnt = 0; tx_clr = 1;
    #1 chk("t6_remain2", tx_remain, 2);
    tick();
    tx_clr = 0;
    chk("t6_busy", tx_busy, 0);
    chk("t6_remain0", tx_remain, 0);
    chk("t6_discard_ready", utx_ready, 1);
    chk("t6_no_req", utx_req, 0);
    utx_valid = 1; utx_data = 32'hDEAD;
    tick();
    utx_valid = 0;
    chk("t6_ready_off", utx_ready, 0);
    chk("t6_jv", jtx_valid, 0);
    chk("t6_busy2", tx_busy, 0);
    chk("t6_no_eot", tx_eot, 0);
    tx_start = 1; tx_len = 16'd1;
    tick();
    tx_start = 0;
    chk("t6_busy_new", tx_busy, 1);
    chk("t6_req_new", utx_req, 1);
    chk("t6_remain1", tx_remain, 1);
    utx_gnt = 1;
    tick();
    utx_gnt = 0;
    chk("t6_req_off", utx_req, 0);
    chk("t6_rdy_new", utx_ready, 1);
    utx_valid = 1; utx_data = 32'hF1;
    tick();
    utx_valid = 0;
    #1;
    chk("t6_jv_new", jtx_valid, 1);
    chk("t6_jd_new", jtx_data, 32'hF1);
    chk("t6_eot", tx_eot, 1);
    tick();
    chk("t6_busy_end", tx_busy, 0);
    chk("t6_eot_once", tx_eot, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
